// File: rtl/fetch_pkg.sv
// Shared widths and payload types for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned DATA_LENGTH = 32;
  localparam int unsigned MEM_LENGTH  = 512;

  // Address width for a word-addressed memory of the given depth.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  localparam int unsigned ADDR_W = addr_width(MEM_LENGTH);
  localparam int unsigned CNT_W  = 2;

  typedef struct packed {
    logic [ADDR_W-1:0]      pc;
    logic [DATA_LENGTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory-side and decoder-side signals of the fetch stage.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic [ADDR_W-1:0]      mem_addr;
  logic                   mem_we;
  logic [DATA_LENGTH-1:0] mem_wdata;
  logic [DATA_LENGTH-1:0] mem_rdata;
  logic [DATA_LENGTH-1:0] instr;
  logic [ADDR_W-1:0]      instr_pc;
  logic                   instr_valid;
  logic                   instr_ready;
  logic                   redirect_valid;
  logic [ADDR_W-1:0]      redirect_pc;
  logic                   halt;

  modport master (
    output mem_addr, mem_we, mem_wdata, instr, instr_pc, instr_valid,
    input  mem_rdata, instr_ready, redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  mem_addr, mem_we, mem_wdata, instr, instr_pc, instr_valid,
    output mem_rdata, instr_ready, redirect_valid, redirect_pc, halt
  );

endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry fetch buffer; head entry is held in its own register so the
// decoder sees a registered instruction word.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     din,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     head_q, head_d;
  fetch_entry_t     tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state for head/tail/count; flush wins over push and pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == '0) head_d = din;
          else               tail_d = din;
          count_d = count_q + CNT_W'(1);
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - CNT_W'(1);
        end
        2'b11: begin
          if (count_q == CNT_W'(1)) begin
            head_d = din;
          end else begin
            head_d = tail_q;
            tail_d = din;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // The issue credit must never let a push land on a full buffer.
  assert property (@(posedge clk) disable iff (rst)
    (push && !pop && !flush) |-> (count_q != CNT_W'(2)));

  assign head  = head_q;
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, one-deep memory read tracking, credit-based
// issue into a two-entry buffer, branch redirect and halt.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
)
(
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic              pop_c, issue_c, push_c;
  logic [2:0]        occupancy_c;
  logic [CNT_W-1:0]  count;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;

  // Issue only when the buffered plus in-flight words still fit after this pop.
  always_comb begin
    pop_c       = bus.instr_valid & bus.instr_ready;
    occupancy_c = 3'(count) + 3'(inflight_q) - 3'(pop_c);
    issue_c     = !bus.redirect_valid && !bus.halt && (occupancy_c < 3'd2);
    push_c      = inflight_q && !bus.redirect_valid;
    push_entry  = '{pc: inflight_pc_q, instr: bus.mem_rdata};
  end

  // Next PC and in-flight tracking; redirect overrides everything.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc;
    end else if (issue_c) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = (pc_q == ADDR_W'(MEM_LENGTH - 1)) ? '0 : pc_q + ADDR_W'(1);
    end
  end

  // PC and in-flight registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_skid_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c && !bus.redirect_valid),
    .flush (bus.redirect_valid),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

  assign bus.mem_addr    = pc_q;
  assign bus.mem_we      = 1'b0;
  assign bus.mem_wdata   = '0;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;
  assign bus.instr_valid = (count != '0);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by random traffic,
// scored against an in-order stream model (next expected pc, mem[i]=i).
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC('0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Word-addressed memory, one-cycle read latency, contents mem[i]=i.
  logic [DATA_LENGTH-1:0] mem [MEM_LENGTH];
  initial for (int i = 0; i < int'(MEM_LENGTH); i++) mem[i] = DATA_LENGTH'(i);
  always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

  int passed = 0;
  int total  = 0;
  int exp_pc = 0;
  logic                   stall_prev = 1'b0;
  logic [DATA_LENGTH-1:0] prev_instr;
  logic [ADDR_W-1:0]      prev_pc;
  int held_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One cycle from a negedge: drive inputs, score any handshake, advance.
  task automatic cycle(input logic rdy, input logic hlt, input logic rdv, input int rpc);
    bus.instr_ready    = rdy;
    bus.halt           = hlt;
    bus.redirect_valid = rdv;
    bus.redirect_pc    = ADDR_W'(rpc);
    if (stall_prev) begin
      check("stall_valid", 32'(bus.instr_valid), 32'd1);
      check("stall_instr", bus.instr, prev_instr);
      check("stall_pc", 32'(bus.instr_pc), 32'(prev_pc));
    end
    if (rdv) begin
      exp_pc = rpc;
    end else if (bus.instr_valid && rdy) begin
      check("seq_pc", 32'(bus.instr_pc), 32'(exp_pc));
      check("seq_instr", bus.instr, 32'(exp_pc));
      exp_pc = (exp_pc + 1) % int'(MEM_LENGTH);
    end
    stall_prev = bus.instr_valid && !rdy && !rdv;
    prev_instr = bus.instr;
    prev_pc    = bus.instr_pc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_values();
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_instr_pc", 32'(bus.instr_pc), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
  endtask

  // Synchronous-looking reset pulse; release lands on a negedge (cycle c0).
  task automatic do_reset();
    rst = 1'b1;
    bus.instr_ready = 1'b0;
    bus.halt = 1'b0;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    exp_pc = 0;
    stall_prev = 1'b0;
  endtask

  initial begin
    bus.instr_ready    = 1'b0;
    bus.halt           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // 1: reset release with ready high; valid in c2, then one per cycle.
    do_reset();
    check("t1_c0_valid", 32'(bus.instr_valid), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    check("t1_c1_valid", 32'(bus.instr_valid), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    check("t1_c2_valid", 32'(bus.instr_valid), 32'd1);
    check("t1_c2_instr", bus.instr, 32'd0);
    check("t1_c2_pc", 32'(bus.instr_pc), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("t1_stream_valid", 32'(bus.instr_valid), 32'd1);
      cycle(1'b1, 1'b0, 1'b0, 0);
    end

    // 2: backpressure for 5 cycles after first valid; buffer full, no issue.
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", 32'(bus.instr_valid), 32'd1);
      check("t2_hold_pc", 32'(bus.instr_pc), 32'd0);
      check("t2_no_issue", 32'(bus.mem_addr), 32'd2);
      cycle(1'b0, 1'b0, 1'b0, 0);
    end
    for (int i = 0; i < 8; i++) begin
      check("t2_resume_valid", 32'(bus.instr_valid), 32'd1);
      cycle(1'b1, 1'b0, 1'b0, 0);
    end

    // 3: redirect mid-stream; dropped words never appear, 0x100 at r+3.
    cycle(1'b1, 1'b0, 1'b1, 'h100);
    check("t3_r1_valid", 32'(bus.instr_valid), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    check("t3_r2_valid", 32'(bus.instr_valid), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    check("t3_r3_valid", 32'(bus.instr_valid), 32'd1);
    check("t3_r3_instr", bus.instr, 32'h100);
    check("t3_r3_pc", 32'(bus.instr_pc), 32'h100);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 0);

    // 4: wrap through the top of memory.
    cycle(1'b1, 1'b0, 1'b1, 510);
    cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      check("t4_wrap_valid", 32'(bus.instr_valid), 32'd1);
      check("t4_wrap_pc", 32'(bus.instr_pc), 32'((510 + k) % 512));
      cycle(1'b1, 1'b0, 1'b0, 0);
    end

    // 5: halt for 4 cycles; drain, go idle, resume at the next sequential pc.
    cycle(1'b1, 1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b0, 0);
    check("t5_drained_valid", 32'(bus.instr_valid), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 0);
    check("t5_idle_valid", 32'(bus.instr_valid), 32'd0);
    check("t5_held_pc", 32'(bus.mem_addr), 32'(exp_pc));
    held_pc = exp_pc;
    cycle(1'b1, 1'b1, 1'b0, 0);
    check("t5_resume_c0_valid", 32'(bus.instr_valid), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    check("t5_resume_c1_valid", 32'(bus.instr_valid), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    check("t5_resume_valid", 32'(bus.instr_valid), 32'd1);
    check("t5_resume_pc", 32'(bus.instr_pc), 32'(held_pc));
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 0);

    // 6: asynchronous reset between edges mid-stream.
    #2 rst = 1'b1;
    #1;
    check("t6_async_valid", 32'(bus.instr_valid), 32'd0);
    check("t6_async_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("t6_async_instr_pc", 32'(bus.instr_pc), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 0;
    stall_prev = 1'b0;
    check("t6_c0_valid", 32'(bus.instr_valid), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    check("t6_c1_valid", 32'(bus.instr_valid), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    check("t6_c2_valid", 32'(bus.instr_valid), 32'd1);
    check("t6_c2_instr", bus.instr, 32'd0);
    check("t6_c2_pc", 32'(bus.instr_pc), 32'd0);

    // Random traffic: ready, halt and redirects scored by the stream model.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
            $urandom_range(0, 19) == 0, int'($urandom_range(0, 511)));
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 0);
    check("rand_live_valid", 32'(bus.instr_valid), 32'd1);
    check("rand_live_pc", 32'(bus.instr_pc), 32'(exp_pc));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
